dmem_mmio_responder: RTL and testbench

//   Responder for the CPU core's data-memory port (ram_addr/ram_data/ram_we/ram_sel/ram_ce).

---
 rtl/dmem_mmio_responder.sv | 264 ++++++++++++++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM with byte lanes plus LED/timer/UART MMIO window.
// Define DMEM_UART_EN to build the UART TX FIFO, serialiser and its registers.
module dmem_mmio_responder #(
  parameter int RAM_AW       = 10,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [15:0] led_o,
  output logic        timer_irq_o,
  output logic        uart_tx_o,
  output logic        bus_err_o
);

  localparam int RAM_WORDS = 2**RAM_AW;

  if (CLKS_PER_BIT < 2 || FIFO_AW < 1 || FIFO_AW > 27) begin : g_param_chk
    $error("dmem_mmio_responder: parameter out of range");
  end

  logic              access;
  logic              ram_hit;
  logic              mmio_hit;
  logic              unmapped;
  logic              rd_en;
  logic              mmio_wr;
  logic [RAM_AW-1:0] ram_idx;
  logic [5:0]        woff;
  logic              off_led;
  logic              off_cnt;
  logic              off_cmp;
  logic              off_udat;
  logic              off_ustat;
  logic              unused_ok;

  assign access    = |ce_i;
  assign ram_hit   = addr_i[31:RAM_AW+2] == '0;
  assign mmio_hit  = addr_i[31:8] == 24'hBFD000;
  assign unmapped  = access && !ram_hit && !mmio_hit;
  assign rd_en     = !rst && access && !we_i;
  assign mmio_wr   = access && we_i && mmio_hit;
  assign ram_idx   = addr_i[RAM_AW+1:2];
  assign woff      = addr_i[7:2];
  assign off_led   = woff == 6'd0;
  assign off_cnt   = woff == 6'd1;
  assign off_cmp   = woff == 6'd2;
  assign off_udat  = woff == 6'd3;
  assign off_ustat = woff == 6'd4;
  assign unused_ok = ^addr_i[1:0];

  logic [31:0] mem [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (access && we_i && ram_hit) begin
      for (int n = 0; n < 4; n++) begin
        if (sel_i[n]) mem[ram_idx][8*n +: 8] <= data_i[8*n +: 8];
      end
    end
  end

  logic [15:0] led_q;
  logic [31:0] cnt_q;
  logic [31:0] cmp_q;
  logic        irq_q;
  logic        err_q;

  // A CMP write in the same cycle as a match keeps the irq clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0;
      cnt_q <= '0;
      cmp_q <= '0;
      irq_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
      err_q <= unmapped;
      if (mmio_wr && off_led) led_q <= data_i[15:0];
      if (mmio_wr && off_cmp) begin
        cmp_q <= data_i;
        irq_q <= 1'b0;
      end else if (cnt_q == cmp_q && cmp_q != '0) begin
        irq_q <= 1'b1;
      end
    end
  end

  logic [31:0] ustat;
  logic        tx;

`ifdef DMEM_UART_EN
  localparam int DEPTH = 2**FIFO_AW;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]    CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_t;

  tx_state_t          state_q;
  tx_state_t          state_d;
  logic [CW-1:0]      clk_q;
  logic [CW-1:0]      clk_d;
  logic [2:0]         bit_q;
  logic [2:0]         bit_d;
  logic [7:0]         sh_q;
  logic [7:0]         sh_d;
  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count_q;
  logic               ovf_q;
  logic               full;
  logic               empty;
  logic               push_req;
  logic               push;
  logic               pop;
  logic               ovf_clr;
  logic               clk_last;

  assign full     = count_q == FULL_CNT;
  assign empty    = count_q == '0;
  assign push_req = mmio_wr && off_udat;
  assign push     = push_req && (!full || pop);
  assign ovf_clr  = mmio_wr && off_ustat && data_i[2];
  assign clk_last = clk_q == CLK_LAST;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push_req && !push) ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      clk_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      clk_q   <= clk_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clk_d   = clk_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = fifo_mem[rd_ptr];
          clk_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        clk_d = clk_q + 1'b1;
        if (clk_last) begin
          clk_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        clk_d = clk_q + 1'b1;
        if (clk_last) begin
          clk_d = '0;
          sh_d  = {1'b0, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        clk_d = clk_q + 1'b1;
        if (clk_last) begin
          clk_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ustat              = '0;
    ustat[0]           = full;
    ustat[1]           = state_q != S_IDLE;
    ustat[2]           = ovf_q;
    ustat[3]           = empty;
    ustat[FIFO_AW+4:4] = count_q;
  end

  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = sh_q[0];
      default: tx = 1'b1;
    endcase
  end
`else
  assign ustat = '0;
  assign tx    = 1'b1;
`endif

  always_comb begin
    data_o = '0;
    if (rd_en) begin
      if (ram_hit) begin
        data_o = mem[ram_idx];
      end else if (mmio_hit) begin
        unique case (1'b1)
          off_led:   data_o = {16'h0, led_q};
          off_cnt:   data_o = cnt_q;
          off_cmp:   data_o = cmp_q;
          off_udat:  data_o = '0;
          off_ustat: data_o = ustat;
          default:   data_o = '0;
        endcase
      end
    end
  end

  assign led_o       = led_q;
  assign timer_irq_o = irq_q;
  assign uart_tx_o   = tx;
  assign bus_err_o   = err_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: RAM lanes, decode, timer irq,
// and (with DMEM_UART_EN) the UART FIFO, framing and reset abort.
module tb_dmem_mmio_responder;

  localparam int CPB = 4;
  localparam logic [31:0] A_LED  = 32'hBFD00000;
  localparam logic [31:0] A_CNT  = 32'hBFD00004;
  localparam logic [31:0] A_CMP  = 32'hBFD00008;
  localparam logic [31:0] A_UDAT = 32'hBFD0000C;
  localparam logic [31:0] A_STAT = 32'hBFD00010;
`ifdef DMEM_UART_EN
  localparam logic [31:0] STAT_IDLE = 32'h8;
`else
  localparam logic [31:0] STAT_IDLE = 32'h0;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [15:0] led_o;
  logic        timer_irq_o;
  logic        uart_tx_o;
  logic        bus_err_o;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_mmio_responder #(
    .RAM_AW(10),
    .CLKS_PER_BIT(CPB),
    .FIFO_AW(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ce_i(ce_i),
    .we_i(we_i),
    .addr_i(addr_i),
    .sel_i(sel_i),
    .data_i(data_i),
    .data_o(data_o),
    .led_o(led_o),
    .timer_irq_o(timer_irq_o),
    .uart_tx_o(uart_tx_o),
    .bus_err_o(bus_err_o)
  );

  typedef struct {
    logic [3:0]  ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic        chk;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;

  vec_t v [21];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_bus(input logic [3:0] ce, input logic we,
                         input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] data);
    ce_i   = ce;
    we_i   = we;
    addr_i = addr;
    sel_i  = sel;
    data_i = data;
  endtask

  task automatic step(input logic [3:0] ce, input logic we,
                      input logic [31:0] addr, input logic [3:0] sel,
                      input logic [31:0] data);
    @(negedge clk);
    set_bus(ce, we, addr, sel, data);
  endtask

  task automatic idle();
    @(negedge clk);
    set_bus(4'h0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_bus(4'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rx_byte(output logic [7:0] b, output logic ok);
    ok = 1'b0;
    b  = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!uart_tx_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      repeat (CPB + CPB / 2) @(negedge clk);
      b[0] = uart_tx_o;
      for (int k = 1; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        b[k] = uart_tx_o;
      end
      repeat (CPB) @(negedge clk);
      if (!uart_tx_o) ok = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] got;
    logic [39:0] exp;
    logic [7:0]  b;
    logic        ok;
    logic        quiet;

    rst = 1'b1;
    set_bus(4'hF, 1'b0, 32'h0, 4'hF, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_led", led_o, 16'h0);
    check("rst_irq", timer_irq_o, 1'b0);
    check("rst_tx", uart_tx_o, 1'b1);
    check("rst_err", bus_err_o, 1'b0);
    check("rst_rdata", data_o, 32'h0);
    rst = 1'b0;
    set_bus(4'h0, 1'b0, 32'h0, 4'h0, 32'h0);

    v[0]  = '{4'hF, 1'b1, 32'h0,    4'hF, 32'h11223344, 1'b0, 32'h0,        1'b0};
    v[1]  = '{4'h1, 1'b1, 32'h0,    4'h4, 32'h00AA0000, 1'b1, 32'h0,        1'b0};
    v[2]  = '{4'h2, 1'b0, 32'h0,    4'h0, 32'h0,        1'b1, 32'h11AA3344, 1'b0};
    v[3]  = '{4'hF, 1'b1, 32'h4,    4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
    v[4]  = '{4'hF, 1'b1, 32'h6,    4'h1, 32'h00000077, 1'b0, 32'h0,        1'b0};
    v[5]  = '{4'h8, 1'b0, 32'h4,    4'hF, 32'h0,        1'b1, 32'hDEADBE77, 1'b0};
    v[6]  = '{4'hF, 1'b1, 32'hFFC,  4'hF, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0};
    v[7]  = '{4'hF, 1'b1, 32'h1000, 4'hF, 32'h12345678, 1'b0, 32'h0,        1'b0};
    v[8]  = '{4'hF, 1'b0, 32'hFFC,  4'hF, 32'h0,        1'b1, 32'hCAFEF00D, 1'b1};
    v[9]  = '{4'hF, 1'b0, 32'h1000, 4'hF, 32'h0,        1'b1, 32'h0,        1'b0};
    v[10] = '{4'hF, 1'b0, 32'h0,    4'hF, 32'h0,        1'b1, 32'h11AA3344, 1'b1};
    v[11] = '{4'h0, 1'b0, 32'h0,    4'hF, 32'h0,        1'b1, 32'h0,        1'b0};
    v[12] = '{4'hF, 1'b1, A_LED,    4'h1, 32'h1234A5A5, 1'b0, 32'h0,        1'b0};
    v[13] = '{4'hF, 1'b0, A_LED,    4'hF, 32'h0,        1'b1, 32'h0000A5A5, 1'b0};
    v[14] = '{4'hF, 1'b0, 32'hBFD00020, 4'hF, 32'h0,    1'b1, 32'h0,        1'b0};
    v[15] = '{4'hF, 1'b1, 32'hBFD00020, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0,    1'b0};
    v[16] = '{4'hF, 1'b0, A_LED,    4'hF, 32'h0,        1'b1, 32'h0000A5A5, 1'b0};
    v[17] = '{4'hF, 1'b0, A_UDAT,   4'hF, 32'h0,        1'b1, 32'h0,        1'b0};
    v[18] = '{4'hF, 1'b0, A_STAT,   4'hF, 32'h0,        1'b1, STAT_IDLE,    1'b0};
    v[19] = '{4'hF, 1'b0, 32'hBFD01000, 4'hF, 32'h0,    1'b1, 32'h0,        1'b0};
    v[20] = '{4'h0, 1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 32'h0,        1'b1};

    for (int i = 0; i < 21; i++) begin
      step(v[i].ce, v[i].we, v[i].addr, v[i].sel, v[i].data);
      #1;
      if (v[i].chk) check($sformatf("vec%0d_rdata", i), data_o, v[i].exp);
      check($sformatf("vec%0d_err", i), bus_err_o, v[i].exp_err);
    end
    check("led_out", led_o, 16'hA5A5);

    // Timer: CNT equals (negedge index - 1) after the reset edge.
    do_reset();
    set_bus(4'hF, 1'b1, A_CMP, 4'hF, 32'd20);
    step(4'hF, 1'b0, A_CNT, 4'hF, 32'h0);
    #1 check("cnt_first", data_o, 32'd1);
    step(4'hF, 1'b0, A_CMP, 4'hF, 32'h0);
    #1 check("cmp_read", data_o, 32'd20);
    idle();
    repeat (17) @(negedge clk);
    check("irq_before_match", timer_irq_o, 1'b0);
    set_bus(4'hF, 1'b0, A_CNT, 4'hF, 32'h0);
    #1 check("cnt_at_match", data_o, 32'd20);
    idle();
    check("irq_set", timer_irq_o, 1'b1);
    repeat (3) @(negedge clk);
    check("irq_sticky", timer_irq_o, 1'b1);
    set_bus(4'hF, 1'b1, A_CMP, 4'hF, 32'd0);
    idle();
    check("irq_clr", timer_irq_o, 1'b0);
    set_bus(4'hF, 1'b1, A_CMP, 4'hF, 32'd30);
    idle();
    repeat (4) @(negedge clk);
    check("irq_pre_race", timer_irq_o, 1'b0);
    set_bus(4'hF, 1'b1, A_CMP, 4'hF, 32'd30);
    idle();
    check("irq_write_wins", timer_irq_o, 1'b0);
    set_bus(4'hF, 1'b0, A_CNT, 4'hF, 32'h0);
    #1 check("cnt_31", data_o, 32'd31);
    step(4'hF, 1'b1, A_CNT, 4'hF, 32'h1000);
    step(4'hF, 1'b0, A_CNT, 4'hF, 32'h0);
    #1 check("cnt_ro", data_o, 32'd33);

`ifdef DMEM_UART_EN
    // Single frame of 0x55.
    do_reset();
    step(4'hF, 1'b1, A_UDAT, 4'h1, 32'h55);
    idle();
    check("tx_idle_after_push", uart_tx_o, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (i == 0) step(4'hF, 1'b0, A_STAT, 4'hF, 32'h0);
      else idle();
      #1;
      got[i] = uart_tx_o;
      if (i < 4) exp[i] = 1'b0;
      else if (i < 36) exp[i] = ((32'h55 >> ((i - 4) / 4)) & 1) != 0;
      else exp[i] = 1'b1;
      if (i == 0) check("stat_busy", data_o, 32'hA);
    end
    check("frame_55", got, exp);
    step(4'hF, 1'b0, A_STAT, 4'hF, 32'h0);
    #1 check("stat_after_frame", data_o, 32'h8);
    check("tx_after_frame", uart_tx_o, 1'b1);

    // Overflow with the serialiser busy on 0xFF.
    do_reset();
    step(4'hF, 1'b1, A_UDAT, 4'h1, 32'hFF);
    idle();
    for (int i = 0; i < 10; i++) step(4'hF, 1'b1, A_UDAT, 4'h1, 32'hA0 + i);
    step(4'hF, 1'b0, A_STAT, 4'hF, 32'h0);
    #1 check("stat_full_ovf", data_o, 32'h87);
    step(4'hF, 1'b1, A_STAT, 4'hF, 32'h4);
    step(4'hF, 1'b0, A_STAT, 4'hF, 32'h0);
    #1 check("stat_ovf_clr", data_o, 32'h83);
    idle();
    for (int i = 0; i < 8; i++) begin
      rx_byte(b, ok);
      check($sformatf("rx%0d_ok", i), ok, 1'b1);
      check($sformatf("rx%0d_byte", i), b, 8'hA0 + i);
    end
    quiet = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!uart_tx_o) quiet = 1'b0;
    end
    check("fifo_drained_quiet", quiet, 1'b1);
    step(4'hF, 1'b0, A_STAT, 4'hF, 32'h0);
    #1 check("stat_drained", data_o, 32'h8);

    // Reset in the middle of a zero byte, second byte queued.
    step(4'hF, 1'b1, A_UDAT, 4'h1, 32'h00);
    step(4'hF, 1'b1, A_UDAT, 4'h1, 32'h33);
    idle();
    check("abort_start", uart_tx_o, 1'b0);
    repeat (8) @(negedge clk);
    check("abort_data_low", uart_tx_o, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx_high", uart_tx_o, 1'b1);
    rst = 1'b0;
    step(4'hF, 1'b0, A_STAT, 4'hF, 32'h0);
    #1 check("abort_fifo_empty", data_o, 32'h8);
    idle();
    quiet = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!uart_tx_o) quiet = 1'b0;
    end
    check("abort_quiet", quiet, 1'b1);
`else
    do_reset();
    step(4'hF, 1'b1, A_UDAT, 4'h1, 32'h41);
    step(4'hF, 1'b1, A_STAT, 4'hF, 32'h4);
    idle();
    check("nouart_no_err", bus_err_o, 1'b0);
    quiet = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!uart_tx_o) quiet = 1'b0;
    end
    check("nouart_tx_high", quiet, 1'b1);
    step(4'hF, 1'b0, A_STAT, 4'hF, 32'h0);
    #1 check("nouart_stat", data_o, 32'h0);
`endif

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
